// File: rtl/alu_pkg.sv
// Shared types and helpers for the pipelined ALU: opcodes, flag layout,
// the saturating adder used by ADD/SUB and PADDSB lanes, and the flag write mask.
package alu_pkg;

    // Width of the scratch arithmetic used by the saturating helpers.
    // Datapaths and lanes up to 63 bits fit without the scratch sum wrapping.
    localparam int unsigned CALC_W = 64;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'ha,
        OP_LHB    = 4'hb,
        OP_B      = 4'hc,
        OP_BR     = 4'hd,
        OP_PCS    = 4'he,
        OP_HLT    = 4'hf
    } opcode_t;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
    } flags_t;

    // Signed add of two sign-extended operands, clamped to the w-bit signed range.
    // Callers truncate the return value to w bits.
    function automatic logic [CALC_W-1:0] sat_add(input logic [CALC_W-1:0] a,
                                                  input logic [CALC_W-1:0] b,
                                                  input int unsigned       w);
        logic signed [CALC_W-1:0] sum;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        sum = $signed(a) + $signed(b);
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        if (sum > hi) begin
            return $unsigned(hi);
        end
        if (sum < lo) begin
            return $unsigned(lo);
        end
        return $unsigned(sum);
    endfunction

    // True when sat_add with the same arguments had to clamp.
    function automatic logic sat_ovf(input logic [CALC_W-1:0] a,
                                     input logic [CALC_W-1:0] b,
                                     input int unsigned       w);
        logic signed [CALC_W-1:0] sum;
        sum = $signed(a) + $signed(b);
        return (sum > ((64'sd1 <<< (w - 1)) - 64'sd1)) || (sum < -(64'sd1 <<< (w - 1)));
    endfunction

    // Which architectural flags an opcode is allowed to write.
    function automatic flags_t flag_mask(input opcode_t op);
        case (op)
            OP_ADD, OP_SUB:                 return flags_t'(3'b111);
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: return flags_t'(3'b010);
            default:                        return flags_t'(3'b000);
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and next {N,Z,V} from opcode, operands and current flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned LANE_W = 4
) (
    input  opcode_t          opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  flags_t           flags_in,
    output logic [WIDTH-1:0] result,
    output flags_t           flags_out
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned LANES   = WIDTH / LANE_W;
    localparam int unsigned BYTES   = WIDTH / 8;

    function automatic logic [CALC_W-1:0] sext_w(input logic [WIDTH-1:0] x);
        return {{(CALC_W-WIDTH){x[WIDTH-1]}}, x};
    endfunction

    function automatic logic [CALC_W-1:0] sext_l(input logic [LANE_W-1:0] x);
        return {{(CALC_W-LANE_W){x[LANE_W-1]}}, x};
    endfunction

    logic [SHAMT_W-1:0] shamt;
    logic [CALC_W-1:0]  a_x;
    logic [CALC_W-1:0]  b_x;
    logic [CALC_W-1:0]  nb_x;
    logic [8:0]         red_sum;
    logic               ovf;
    logic [2:0]         calc;
    logic [2:0]         mask;

    assign shamt = in_b[SHAMT_W-1:0];
    assign a_x   = sext_w(in_a);
    assign b_x   = sext_w(in_b);
    assign nb_x  = '0 - b_x;

    // Result selection per opcode; ovf only ever set by ADD/SUB.
    always_comb begin
        result  = '0;
        ovf     = 1'b0;
        red_sum = '0;
        case (opcode)
            OP_ADD: begin
                result = WIDTH'(sat_add(a_x, b_x, WIDTH));
                ovf    = sat_ovf(a_x, b_x, WIDTH);
            end
            OP_SUB: begin
                result = WIDTH'(sat_add(a_x, nb_x, WIDTH));
                ovf    = sat_ovf(a_x, nb_x, WIDTH);
            end
            OP_XOR: result = in_a ^ in_b;
            OP_SLL: result = in_a << shamt;
            OP_SRA: result = $signed(in_a) >>> shamt;
            OP_ROR: result = WIDTH'({in_a, in_a} >> shamt);
            OP_PADDSB: begin
                for (int i = 0; i < LANES; i++) begin
                    result[i*LANE_W +: LANE_W] = LANE_W'(sat_add(sext_l(in_a[i*LANE_W +: LANE_W]),
                                                                 sext_l(in_b[i*LANE_W +: LANE_W]),
                                                                 LANE_W));
                end
            end
            OP_RED: begin
                for (int i = 0; i < BYTES; i++) begin
                    red_sum = red_sum + {1'b0, in_a[i*8 +: 8]} + {1'b0, in_b[i*8 +: 8]};
                end
                result = {{(WIDTH-9){red_sum[8]}}, red_sum};
            end
            OP_LLB:        result = {in_a[WIDTH-1:8], in_b[7:0]};
            OP_LHB:        result = {in_b[7:0], in_a[WIDTH-9:0]};
            OP_LW, OP_SW:  result = in_a + in_b;
            default:       result = in_a;
        endcase
    end

    // Merge freshly computed flags into the current ones under the opcode's write mask.
    always_comb begin
        calc      = {result[WIDTH-1], (result == '0), ovf};
        mask      = flag_mask(opcode);
        flags_out = flags_t'((flags_in & ~mask) | (calc & mask));
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake, flush and an owned N/Z/V register.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned LANE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_pkg::opcode_t opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    // Handshake: a transfer happens on an edge where valid && ready were both high.
    // Stage 2 advances when empty or when its result is taken; stage 1 moves into
    // stage 2 only when stage 2 advances. Flush drops everything in flight and the
    // offered op, so in_ready is forced high while it is asserted.

    logic             s1_valid_q, s1_valid_d;
    opcode_t          s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q,   s2_res_d;
    flags_t           flags_q,    flags_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic [WIDTH-1:0] core_res;
    flags_t           core_flags;

    // Computes on stage-1 contents; flags committed by the op ahead are already visible.
    alu_core #(
        .WIDTH  (WIDTH),
        .LANE_W (LANE_W)
    ) u_core (
        .opcode    (s1_op_q),
        .in_a      (s1_a_q),
        .in_b      (s1_b_q),
        .flags_in  (flags_q),
        .result    (core_res),
        .flags_out (core_flags)
    );

    // Handshake control and next-state for both stages and the flag register.
    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = s1_valid_q && s2_adv;
        in_ready   = flush || !s1_valid_q || s2_adv;
        accept     = in_valid && in_ready && !flush;
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        flags_d    = flags_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid_d = s1_valid_q;
            end
            if (s1_adv) begin
                s2_res_d = core_res;
                flags_d  = core_flags;
            end
            if (in_ready) begin
                s1_valid_d = in_valid;
            end
            if (accept) begin
                s1_op_d = opcode;
                s1_a_d  = in_a;
                s1_b_d  = in_b;
            end
        end
    end

    // Pipeline and flag registers; reset clears everything including flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_ADD;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            flags_q    <= flags_t'(3'b000);
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            flags_q    <= flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_res_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=16, LANE_W=4) with hand-computed expectations.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned LANE_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    opcode_t          opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [2:0]       flags;

    int n_vec = 0;
    int n_err = 0;

    alu_pipe #(.WIDTH(WIDTH), .LANE_W(LANE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    // Clock
    always #5 clk = ~clk;

    // Drivers: inputs change 1 time unit after a rising edge, outputs sampled on falling edges.
    task automatic drive_op(input opcode_t op, input logic [15:0] a, input logic [15:0] b);
        opcode   = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
    endtask

    // Issue one op into an empty pipe and sample out_valid one and two edges after capture.
    task automatic apply_single(input opcode_t op, input logic [15:0] a, input logic [15:0] b,
                                output logic early_v, output logic late_v,
                                output logic [15:0] res, output logic [2:0] flg);
        drive_op(op, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        early_v = out_valid;
        @(posedge clk); #1;
        @(negedge clk);
        late_v = out_valid;
        res    = result;
        flg    = flags;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        opcode    = OP_ADD;
        in_a      = '0;
        in_b      = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        n_vec++; if (result !== 16'h0000) begin n_err++; $display("FAIL reset result got %h want 0000", result); end
        n_vec++; if (flags !== 3'b000) begin n_err++; $display("FAIL reset flags got %b want 000", flags); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        opcode_t     ops[4];
        logic [15:0] av[4], bv[4], er[4];
        logic [2:0]  ef[4];
        logic        ev, lv;
        logic [15:0] res;
        logic [2:0]  flg;
        ops = '{OP_ADD, OP_ADD, OP_SUB, OP_ADD};
        av  = '{16'h0001, 16'h7fff, 16'h8000, 16'h8000};
        bv  = '{16'hffff, 16'h0001, 16'h0001, 16'h8000};
        er  = '{16'h0000, 16'h7fff, 16'h8000, 16'h8000};
        ef  = '{3'b010,   3'b001,   3'b101,   3'b101};
        for (int i = 0; i < 4; i++) begin
            apply_single(ops[i], av[i], bv[i], ev, lv, res, flg);
            n_vec++; if (ev !== 1'b0) begin n_err++; $display("FAIL add_sub[%0d] early out_valid got %b want 0", i, ev); end
            n_vec++; if (lv !== 1'b1) begin n_err++; $display("FAIL add_sub[%0d] out_valid got %b want 1", i, lv); end
            n_vec++; if (res !== er[i]) begin n_err++; $display("FAIL add_sub[%0d] result got %h want %h", i, res, er[i]); end
            n_vec++; if (flg !== ef[i]) begin n_err++; $display("FAIL add_sub[%0d] flags got %b want %b", i, flg, ef[i]); end
        end
    endtask

    task automatic test_paddsb_xor();
        opcode_t     ops[3];
        logic [15:0] av[3], bv[3], er[3];
        logic [2:0]  ef[3];
        logic        ev, lv;
        logic [15:0] res;
        logic [2:0]  flg;
        ops = '{OP_PADDSB, OP_XOR,   OP_PADDSB};
        av  = '{16'h7788,  16'h1234, 16'h1234};
        bv  = '{16'h1188,  16'h1234, 16'h1111};
        er  = '{16'h7788,  16'h0000, 16'h2345};
        ef  = '{3'b101,    3'b111,   3'b111};
        for (int i = 0; i < 3; i++) begin
            apply_single(ops[i], av[i], bv[i], ev, lv, res, flg);
            n_vec++; if (lv !== 1'b1) begin n_err++; $display("FAIL paddsb_xor[%0d] out_valid got %b want 1", i, lv); end
            n_vec++; if (res !== er[i]) begin n_err++; $display("FAIL paddsb_xor[%0d] result got %h want %h", i, res, er[i]); end
            n_vec++; if (flg !== ef[i]) begin n_err++; $display("FAIL paddsb_xor[%0d] flags got %b want %b", i, flg, ef[i]); end
        end
    endtask

    task automatic test_shifts();
        opcode_t     ops[5];
        logic [15:0] av[5], bv[5], er[5];
        logic [2:0]  ef[5];
        logic        ev, lv;
        logic [15:0] res;
        logic [2:0]  flg;
        ops = '{OP_ROR,   OP_SLL,   OP_SRA,   OP_SLL,   OP_ROR};
        av  = '{16'h8001, 16'h8000, 16'h8000, 16'h0001, 16'h1234};
        bv  = '{16'h0001, 16'h0001, 16'h000f, 16'h0010, 16'h0004};
        er  = '{16'hc000, 16'h0000, 16'hffff, 16'h0001, 16'h4123};
        ef  = '{3'b101,   3'b111,   3'b101,   3'b101,   3'b101};
        for (int i = 0; i < 5; i++) begin
            apply_single(ops[i], av[i], bv[i], ev, lv, res, flg);
            n_vec++; if (lv !== 1'b1) begin n_err++; $display("FAIL shifts[%0d] out_valid got %b want 1", i, lv); end
            n_vec++; if (res !== er[i]) begin n_err++; $display("FAIL shifts[%0d] result got %h want %h", i, res, er[i]); end
            n_vec++; if (flg !== ef[i]) begin n_err++; $display("FAIL shifts[%0d] flags got %b want %b", i, flg, ef[i]); end
        end
    endtask

    task automatic test_load_red();
        opcode_t     ops[6];
        logic [15:0] av[6], bv[6], er[6];
        logic        ev, lv;
        logic [15:0] res;
        logic [2:0]  flg;
        ops = '{OP_RED,   OP_LLB,   OP_LHB,   OP_LW,    OP_RED,   OP_HLT};
        av  = '{16'h00ff, 16'habcd, 16'habcd, 16'hfff0, 16'h0102, 16'h5a5a};
        bv  = '{16'h0001, 16'h0012, 16'h0012, 16'h0020, 16'h0304, 16'h0000};
        er  = '{16'hff00, 16'hab12, 16'h12cd, 16'h0010, 16'h000a, 16'h5a5a};
        for (int i = 0; i < 6; i++) begin
            apply_single(ops[i], av[i], bv[i], ev, lv, res, flg);
            n_vec++; if (res !== er[i]) begin n_err++; $display("FAIL load_red[%0d] result got %h want %h", i, res, er[i]); end
            n_vec++; if (flg !== 3'b101) begin n_err++; $display("FAIL load_red[%0d] flags got %b want 101", i, flg); end
        end
    endtask

    // Three ops on consecutive cycles with no stall; each sees flags left by the one ahead.
    task automatic test_back_to_back();
        logic [15:0] er[3];
        logic [2:0]  ef[3];
        er = '{16'h8000, 16'h0000, 16'h0005};
        ef = '{3'b101,   3'b111,   3'b000};
        out_ready = 1'b1;
        drive_op(OP_SUB, 16'h8000, 16'h0001);
        @(posedge clk); #1;
        drive_op(OP_XOR, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        drive_op(OP_ADD, 16'h0002, 16'h0003);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b[%0d] out_valid got %b want 1", i, out_valid); end
            n_vec++; if (result !== er[i]) begin n_err++; $display("FAIL b2b[%0d] result got %h want %h", i, result, er[i]); end
            n_vec++; if (flags !== ef[i]) begin n_err++; $display("FAIL b2b[%0d] flags got %b want %b", i, flags, ef[i]); end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b drained out_valid got %b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_q[$];
        logic [15:0] exp_v;
        int          got;
        got       = 0;
        out_ready = 1'b0;
        drive_op(OP_LW, 16'h0001, 16'h0002);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp accept0 in_ready got %b want 1", in_ready); end
        exp_q.push_back(16'h0003);
        @(posedge clk); #1;
        drive_op(OP_LW, 16'h0010, 16'h0020);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp accept1 in_ready got %b want 1", in_ready); end
        exp_q.push_back(16'h0030);
        @(posedge clk); #1;
        drive_op(OP_LW, 16'h0100, 16'h0200);
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(negedge clk);
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp full[%0d] in_ready got %b want 0", cyc, in_ready); end
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp hold[%0d] out_valid got %b want 1", cyc, out_valid); end
            n_vec++; if (result !== 16'h0003) begin n_err++; $display("FAIL bp hold[%0d] result got %h want 0003", cyc, result); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp release in_ready got %b want 1", in_ready); end
                exp_q.push_back(16'h0300);
            end
            if (out_valid === 1'b1) begin
                got++;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL bp drain extra result got %h want none", result);
                end else begin
                    exp_v = exp_q.pop_front();
                    n_vec++; if (result !== exp_v) begin n_err++; $display("FAIL bp drain result got %h want %h", result, exp_v); end
                end
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        n_vec++; if (got !== 3) begin n_err++; $display("FAIL bp drain count got %0d want 3", got); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive_op(OP_SUB, 16'h0001, 16'h0002);
        @(posedge clk); #1;
        drive_op(OP_XOR, 16'h0005, 16'h0005);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (result !== 16'hffff) begin n_err++; $display("FAIL flush pre result got %h want ffff", result); end
        n_vec++; if (flags !== 3'b100) begin n_err++; $display("FAIL flush pre flags got %b want 100", flags); end
        @(posedge clk); #1;
        flush     = 1'b1;
        out_ready = 1'b1;
        drive_op(OP_LLB, 16'h1111, 16'h0022);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush out_valid got %b want 0", out_valid); end
        n_vec++; if (flags !== 3'b100) begin n_err++; $display("FAIL flush flags got %b want 100", flags); end
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush dropped op out_valid got %b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        logic        ev, lv;
        logic [15:0] res;
        logic [2:0]  flg;
        out_ready = 1'b0;
        drive_op(OP_ADD, 16'h7fff, 16'h0001);
        @(posedge clk); #1;
        drive_op(OP_LLB, 16'h0001, 16'h0002);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (flags !== 3'b001) begin n_err++; $display("FAIL arst pre flags got %b want 001", flags); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst out_valid got %b want 0", out_valid); end
        n_vec++; if (flags !== 3'b000) begin n_err++; $display("FAIL arst flags got %b want 000", flags); end
        n_vec++; if (result !== 16'h0000) begin n_err++; $display("FAIL arst result got %h want 0000", result); end
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst in_ready got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst lost ops out_valid got %b want 0", out_valid); end
        @(posedge clk); #1;
        apply_single(OP_ADD, 16'h0001, 16'h0002, ev, lv, res, flg);
        n_vec++; if (res !== 16'h0003) begin n_err++; $display("FAIL arst recover result got %h want 0003", res); end
        n_vec++; if (flg !== 3'b000) begin n_err++; $display("FAIL arst recover flags got %b want 000", flg); end
    endtask

    // Sequence of scenarios, then the summary line.
    initial begin
        test_reset();
        test_add_sub();
        test_paddsb_xor();
        test_shifts();
        test_load_red();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle WISC ALU.
- Sits between decode/register-read and writeback.
- Accepts one operation per cycle over a valid/ready handshake and stalls under backpressure.
- Owns the architectural N/Z/V flag register, removing the external flagsIn/flagsOut loop.

Parameters:
WIDTH, 16, datapath width; power of 2, >= 16
LANE_W, 4, PADDSB lane width; must divide WIDTH, >= 2
SHAMT_W, $clog2(WIDTH), shift amount bits taken from in_b (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  operation offered
in_ready  out  1  stage 1 can accept
opcode  in  4  alu_pkg::opcode_t
in_a  in  WIDTH  operand 1
in_b  in  WIDTH  operand 2 / immediate
flush  in  1  discard all in-flight ops
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  WIDTH  result of oldest op
flags  out  3  committed {N,Z,V}

Behaviour:
- Reset, asynchronous, active-high: s1_valid=0, s2_valid=0, out_valid=0, result=0, flags=3'b000, in_ready=1 on the first cycle after release.
- Latency: an op accepted at edge k (in_valid&&in_ready) presents out_valid at edge k+2 when there is no stall.
- Ordering is strictly in order. Holds max 2 ops.
- Stage-2 advance is s2_adv = !s2_valid || out_ready.
- Stage 1 -> stage 2 move is s1_adv = s1_valid && s2_adv. in_ready = !s1_valid || s2_adv.
- While out_valid && !out_ready: result and out_valid are held stable.
- Stage 1 registers opcode and operands. Stage 2 computes and registers result and next flags.
- Arithmetic, signed two's complement, WIDTH bits:
  - ADD/SUB: saturating. Overflow clamps to 0x7f..f or 0x80..0 and sets V.
  - XOR: bitwise.
  - SLL: in_a << in_b[SHAMT_W-1:0].
  - SRA: arithmetic right shift by the same amount.
  - ROR: rotate right by the same amount; a shift of 0 returns in_a.
  - PADDSB: independent LANE_W-bit signed lanes, each saturating to +2^(LANE_W-1)-1 / -2^(LANE_W-1). Flags unchanged.
  - RED: sum all bytes of in_a and in_b as unsigned, modulo 2^9, sign-extend bit 8 to WIDTH. Flags unchanged.
  - LLB: {in_a[WIDTH-1:8], in_b[7:0]}.
  - LHB: {in_b[7:0], in_a[WIDTH-9:0]}.
  - LW/SW: in_a + in_b, wrapping (address).
  - B/BR/PCS/HLT: pass in_a. Flags unchanged.
- Flag update, applied when the op enters stage 2:
  - ADD/SUB write N, Z, V. Z = (result==0) after saturation; N = result MSB.
  - XOR/SLL/SRA/ROR write Z only.
  - Every other opcode leaves all flags unchanged.
- Flag forwarding: an op in stage 1 with s1_adv sees flags already updated by the op ahead of it, since the flag register commits at stage-2 entry.
- flush: clears s1_valid and s2_valid on the next edge. Flags are not rolled back. An op offered in the same cycle as flush is dropped and in_ready=1 that cycle.
- Simultaneous stall and accept with stage 1 full and s2 stalled: in_ready=0 and no capture.
- Reset mid-operation: in-flight ops are lost and flags return to 0.

Decomposition:
- alu_pkg:
  - opcode_t enum (ADD=0 … HLT=0xf)
  - flags_t struct {N,Z,V}
  - functions sat_add(a,b,w) and flag_mask(opcode)
- Sub-module alu_core: purely combinational compute of result plus next flags from opcode, operands and current flags. Parametrised WIDTH/LANE_W, instantiated in stage 2.
- alu_pipe holds only the handshake registers and the flag register.

Test Plan (WIDTH=16, LANE_W=4):
- ADD 0x7fff+0x0001 -> result 0x7fff at accept+2, flags N=0 Z=0 V=1. Then SUB 0x8000-0x0001 -> 0x8000, N=1 Z=0 V=1.
- PADDSB 0x7788+0x1188 -> 0x7788; a following XOR 0x1234^0x1234 -> 0x0000 with Z=1 and N,V unchanged from the prior ADD/SUB.
- ROR 0x8001 by in_b=0x0001 -> 0xc000. SRA 0x8000 by 0x000f -> 0xffff, Z=0. SLL 0x0001 by 0x0010 (shamt 0) -> 0x0001.
- RED in_a=0x00ff, in_b=0x0001 -> 0xff00, flags unchanged. LLB in_a=0xabcd, in_b=0x0012 -> 0xab12. LHB same operands -> 0x12cd.
- Backpressure: issue 3 back-to-back ops with out_ready=0 -> in_ready falls after 2 accepts. Raising out_ready drains results in order at one per cycle with no loss or duplication.
- flush with 2 ops in flight -> out_valid=0 the next cycle and flags keep their pre-flush value. Asserting rst mid-stream -> out_valid=0 and flags=000 immediately (asynchronous).
